// File: rtl/div_ctrl_32.sv
// rtl/div_ctrl_32.sv - 32-bit signed/unsigned restoring divider controller
//
// Purpose: sequential divider, one quotient bit per clock. The IDLE state
// captures the operands, CALC runs 32 restoring steps, FIX applies the result
// signs, and DONE pulses done for one cycle. A zero divisor goes from IDLE
// straight to DONE with quotient all-ones, remainder = dividend and
// div_by_zero set.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        divide request, sampled only in IDLE
//   is_signed    1 = two's complement divide, 0 = unsigned (captured with start)
//   s, t         dividend and divisor (captured with start)
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   quotient     registered result
//   remainder    registered result
//   div_by_zero  registered flag, updated at each completion
//
// Configuration: define DIV_CTRL_EARLY_OUT_EN so that operations with
// |s| < |t| skip CALC and go straight to FIX.

module div_ctrl_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [31:0] acc;        // dividend shifts out MSB-first; quotient bits shift in
  logic [31:0] prem;       // partial remainder, always below the divisor
  logic [31:0] dvsr;       // divisor magnitude
  logic [5:0]  cnt;
  logic        sgn;
  logic        s_neg;
  logic        t_neg;

  logic [31:0] s_mag;
  logic [31:0] t_mag;
  logic [32:0] rs;         // 33-bit shifted partial remainder
  logic [32:0] diff;
  logic        qbit;
  logic        early;

  assign s_mag = (is_signed && s[31]) ? -s : s;
  assign t_mag = (is_signed && t[31]) ? -t : t;

  // A borrow out of the trial subtraction means the divisor did not fit:
  // keep the shifted remainder and emit a 0 quotient bit.
  assign rs   = {prem, acc[31]};
  assign diff = rs - {1'b0, dvsr};
  assign qbit = ~diff[32];

`ifdef DIV_CTRL_EARLY_OUT_EN
  assign early = (s_mag < t_mag);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      prem        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      sgn         <= 1'b0;
      s_neg       <= 1'b0;
      t_neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sgn   <= is_signed;
            s_neg <= is_signed & s[31];
            t_neg <= is_signed & t[31];
            busy  <= 1'b1;
            if (t == 32'd0) begin
              quotient    <= 32'hFFFF_FFFF;
              remainder   <= s;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else if (early) begin
              // Quotient magnitude is 0 and the remainder is |s|.
              dvsr  <= t_mag;
              acc   <= '0;
              prem  <= s_mag;
              cnt   <= '0;
              state <= FIX;
            end else begin
              dvsr  <= t_mag;
              acc   <= s_mag;
              prem  <= '0;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= qbit ? diff[31:0] : rs[31:0];
          acc  <= {acc[30:0], qbit};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          // The quotient is negative when the operand signs differ. The
          // remainder takes the sign of the dividend. The most negative
          // dividend divided by -1 wraps back to itself.
          quotient    <= (sgn && (s_neg ^ t_neg)) ? -acc : acc;
          remainder   <= (sgn && s_neg) ? -prem : prem;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl_32.sv
// tb/tb_div_ctrl_32.sv - directed self-checking bench for div_ctrl_32
module tb_div_ctrl_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] s;
  logic [31:0] t;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors = 0;
  int errors  = 0;
  int lat;
  int exp_early_lat;
  logic seen;

  always #5 clk = ~clk;

  div_ctrl_32 dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .s(s), .t(t), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one start at a negedge and counts edges, including the sampling
  // edge, until done is seen high. Gives up after 100 edges.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
    @(negedge clk);
    is_signed = sg; s = a; t = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s = 32'hDEAD_BEEF; t = 32'h0000_0003; is_signed = ~sg;
    edges = 1;
    while (edges < 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      edges++;
    end
  endtask

  initial begin
`ifdef DIV_CTRL_EARLY_OUT_EN
    exp_early_lat = 2;
`else
    exp_early_lat = 34;
`endif
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; s = '0; t = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

    // start together with reset is ignored
    start = 1'b1; t = 32'd5; s = 32'd20;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", {31'd0, busy}, 32'd0);

    // -7 / 2 signed
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    check("neg7_lat", lat, 34);
    check("neg7_quot", quotient, 32'hFFFF_FFFD);
    check("neg7_rem", remainder, 32'hFFFF_FFFF);
    check("neg7_dbz", {31'd0, div_by_zero}, 32'd0);
    check("neg7_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("neg7_done_pulse", {31'd0, done}, 32'd0);
    check("neg7_idle_busy", {31'd0, busy}, 32'd0);

    // 7 / -2 signed
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    check("p7_quot", quotient, 32'hFFFF_FFFD);
    check("p7_rem", remainder, 32'd1);

    // divide by zero
    do_div(1'b0, 32'h1234_5678, 32'd0, lat);
    check("dz_lat", lat, 1);
    check("dz_quot", quotient, 32'hFFFF_FFFF);
    check("dz_rem", remainder, 32'h1234_5678);
    check("dz_dbz", {31'd0, div_by_zero}, 32'd1);

    // signed overflow
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("ovf_quot", quotient, 32'h8000_0000);
    check("ovf_rem", remainder, 32'd0);
    check("ovf_dbz", {31'd0, div_by_zero}, 32'd0);

    // unsigned full-width
    do_div(1'b0, 32'hFFFF_FFFF, 32'd2, lat);
    check("uns_lat", lat, 34);
    check("uns_quot", quotient, 32'h7FFF_FFFF);
    check("uns_rem", remainder, 32'd1);

    // reset during CALC at iteration 10
    @(negedge clk);
    is_signed = 1'b0; s = 32'd1000; t = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    check("mid_quot", quotient, 32'd0);
    check("mid_rem", remainder, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("mid_no_done", {31'd0, seen}, 32'd0);
    do_div(1'b0, 32'd100, 32'd7, lat);
    check("post_lat", lat, 34);
    check("post_quot", quotient, 32'd14);
    check("post_rem", remainder, 32'd2);

    // second start during CALC and during DONE is ignored
    @(negedge clk);
    is_signed = 1'b0; s = 32'd50; t = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    s = 32'd99; t = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (done) break;
      lat++;
    end
    check("busy_lat_bound", {31'd0, done}, 32'd1);
    start = 1'b1; s = 32'd77; t = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_quot", quotient, 32'd10);
    check("busy_rem", remainder, 32'd0);
    @(negedge clk);
    check("busy_done_ignored", {31'd0, busy}, 32'd0);

    // small dividend: early out when enabled, same results either way
    do_div(1'b0, 32'd5, 32'd9, lat);
    check("small_lat", lat, exp_early_lat);
    check("small_quot", quotient, 32'd0);
    check("small_rem", remainder, 32'd5);

    // signed small dividend keeps its sign on the remainder
    do_div(1'b1, 32'hFFFF_FFFB, 32'd9, lat);
    check("small_neg_quot", quotient, 32'd0);
    check("small_neg_rem", remainder, 32'hFFFF_FFFB);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
